// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants, the coordinate type and a range helper.
package vga_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned H_TOTAL   = 800;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned V_TOTAL   = 525;

    // Sync windows are half-open: [START, END)
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int unsigned SYNC_DELAY_MAX = 4;

    typedef logic [9:0] coord_t;

    function automatic logic in_window(coord_t c, int unsigned lo, int unsigned hi);
        return (c >= coord_t'(lo)) && (c < coord_t'(hi));
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing outputs of vga_timing_gen toward the renderer / DAC.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic        hs;
    logic        vs;
    logic        blank;
    coord_t      DrawX;
    coord_t      DrawY;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (output hs, vs, blank, DrawX, DrawY, frame_start, frame_count);
    modport slave  (input  hs, vs, blank, DrawX, DrawY, frame_start, frame_count);

endinterface

// File: rtl/vga_sync_delay.sv
// DEPTH-stage shift register resetting to 1 (idle level of active-low sync); DEPTH=0 is a wire.
module vga_sync_delay #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_reset;
        assign unused_clk_reset = clk ^ reset;
        assign dout = din;
    end else begin : g_shift
        logic [DEPTH-1:0] stage;

        always_ff @(posedge clk) begin
            if (reset) begin
                stage <= '1;
            end else begin
                stage <= (stage << 1) | DEPTH'(din);
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator. Optional macro VGA_SYNC_ALIGN_EN delays hs/vs by
// SYNC_DELAY cycles to line up with registered RGB; without it SYNC_DELAY is unused.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned SYNC_DELAY = 1
) (
    input  logic             vga_clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

`ifdef VGA_SYNC_ALIGN_EN
    localparam int unsigned DEPTH = SYNC_DELAY;
`else
    localparam int unsigned DEPTH = 0;
`endif

    if (SYNC_DELAY > SYNC_DELAY_MAX) begin : g_delay_range
        $error("vga_timing_gen: SYNC_DELAY out of range 0..4");
    end

    coord_t      hc;
    coord_t      vc;
    logic        running;
    logic [15:0] frame_count;
    logic        h_end;
    logic        v_end;
    logic        hs_raw;
    logic        vs_raw;
    logic        hs_out;
    logic        vs_out;

    assign h_end = (hc == H_LAST);
    assign v_end = (vc == V_LAST);

    // Counters hold at the origin for the first cycle out of reset so pixel (0,0)
    // is presented with blank and frame_start high before counting begins.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            frame_count <= '0;
            running     <= 1'b0;
        end else begin
            running <= 1'b1;
            if (running) begin
                if (h_end) begin
                    hc <= '0;
                    vc <= v_end ? '0 : vc + coord_t'(1);
                    if (v_end) begin
                        frame_count <= frame_count + 16'd1;
                    end
                end else begin
                    hc <= hc + coord_t'(1);
                end
            end
        end
    end

    assign hs_raw = !in_window(hc, H_SYNC_START, H_SYNC_END);
    assign vs_raw = !in_window(vc, V_SYNC_START, V_SYNC_END);

    vga_sync_delay #(.DEPTH(DEPTH)) u_hs_delay (
        .clk   (vga_clk),
        .reset (reset),
        .din   (hs_raw),
        .dout  (hs_out)
    );

    vga_sync_delay #(.DEPTH(DEPTH)) u_vs_delay (
        .clk   (vga_clk),
        .reset (reset),
        .din   (vs_raw),
        .dout  (vs_out)
    );

    assign vga.hs          = hs_out;
    assign vga.vs          = vs_out;
    assign vga.DrawX       = hc;
    assign vga.DrawY       = vc;
    assign vga.blank       = running && (hc < coord_t'(H_VISIBLE)) && (vc < coord_t'(V_VISIBLE));
    assign vga.frame_start = running && (hc == '0) && (vc == '0);
    assign vga.frame_count = frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; long frame stretches are skipped with back-door forces.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_ALIGN_EN
    localparam int unsigned D = 1;
`else
    localparam int unsigned D = 0;
`endif
    localparam int unsigned SKIP = 476 * 800;

    logic        vga_clk;
    logic        reset;
    int unsigned checks;
    int unsigned errors;
    int unsigned steps;

    vga_timing_gen_if vga ();

    vga_timing_gen #(.SYNC_DELAY(1)) dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .vga     (vga)
    );

    always #20 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
        steps++;
    endtask

    initial begin
        #(60000 * 40);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0, period, hs_low, hs_first, vs_low, vs_first_x, vs_first_y, fs_pulses;
        int unsigned prev_x, prev_y, prev_fc;
        logic jumped, seen_fs;

        vga_clk = 1'b0;
        reset   = 1'b1;
        checks  = 0;
        errors  = 0;
        steps   = 0;

        // Held in reset for three cycles
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_hs", 32'(vga.hs), 1);
            check("rst_vs", 32'(vga.vs), 1);
            check("rst_blank", 32'(vga.blank), 0);
            check("rst_x", 32'(vga.DrawX), 0);
            check("rst_y", 32'(vga.DrawY), 0);
            check("rst_fs", 32'(vga.frame_start), 0);
        end
        check("rst_fc", 32'(vga.frame_count), 0);

        reset = 1'b0;
        step();
        check("first_x", 32'(vga.DrawX), 0);
        check("first_y", 32'(vga.DrawY), 0);
        check("first_blank", 32'(vga.blank), 1);
        check("first_fs", 32'(vga.frame_start), 1);
        check("first_hs", 32'(vga.hs), 1);
        check("first_vs", 32'(vga.vs), 1);
        check("first_fc", 32'(vga.frame_count), 0);
        t0 = steps;

        // One full line
        hs_low = 0;
        hs_first = 1023;
        for (int i = 0; i < 800; i++) begin
            check("line_x_seq", 32'(vga.DrawX), 32'(i));
            if (vga.DrawX == 10'd639) check("blank_x639", 32'(vga.blank), 1);
            if (vga.DrawX == 10'd640) check("blank_x640", 32'(vga.blank), 0);
            if (vga.hs === 1'b0) begin
                hs_low++;
                if (hs_first == 1023) hs_first = 32'(vga.DrawX);
            end
            step();
        end
        check("hs_low_len", hs_low, 96);
        check("hs_first_x", hs_first, 656 + D);
        check("wrap_x", 32'(vga.DrawX), 0);
        check("wrap_y", 32'(vga.DrawY), 1);
        check("wrap_fs", 32'(vga.frame_start), 0);

        // Rest of the frame; lines 2..477 are skipped by preloading vc at (0,2)
        vs_low = 0;
        vs_first_x = 1023;
        vs_first_y = 1023;
        jumped = 1'b0;
        seen_fs = 1'b0;
        period = 0;
        prev_x = 0;
        prev_y = 0;
        prev_fc = 0;
        for (int n = 0; n < 45000 && !seen_fs; n++) begin
            if (!jumped && vga.DrawX == 10'd0 && vga.DrawY == 10'd2) begin
                force dut.vc = 10'd478;
                #1;
                release dut.vc;
                jumped = 1'b1;
            end
            if (vga.frame_start === 1'b1) begin
                seen_fs = 1'b1;
                period = steps - t0 + SKIP;
            end else begin
                if (vga.DrawX == 10'd0 && vga.DrawY == 10'd479) check("blank_y479", 32'(vga.blank), 1);
                if (vga.DrawX == 10'd639 && vga.DrawY == 10'd479) check("blank_x639_y479", 32'(vga.blank), 1);
                if (vga.DrawX == 10'd640 && vga.DrawY == 10'd479) check("blank_x640_y479", 32'(vga.blank), 0);
                if (vga.DrawX == 10'd0 && vga.DrawY == 10'd480) check("blank_y480", 32'(vga.blank), 0);
                if (vga.vs === 1'b0) begin
                    vs_low++;
                    if (vs_first_y == 1023) begin
                        vs_first_x = 32'(vga.DrawX);
                        vs_first_y = 32'(vga.DrawY);
                    end
                end
                prev_x = 32'(vga.DrawX);
                prev_y = 32'(vga.DrawY);
                prev_fc = 32'(vga.frame_count);
                step();
            end
        end
        check("frame_seen", 32'(seen_fs), 1);
        check("frame_period", period, 420000);
        check("vs_low_len", vs_low, 1600);
        check("vs_first_y", vs_first_y, 490);
        check("vs_first_x", vs_first_x, D);
        check("last_x", prev_x, 799);
        check("last_y", prev_y, 524);
        check("last_fc", prev_fc, 0);
        check("frame_fc", 32'(vga.frame_count), 1);
        check("frame_x", 32'(vga.DrawX), 0);
        check("frame_y", 32'(vga.DrawY), 0);

        // frame_count wrap: preset 65535 on the last line
        step();
        force dut.vc = 10'd524;
        force dut.frame_count = 16'hFFFF;
        #1;
        release dut.vc;
        release dut.frame_count;
        check("preset_y", 32'(vga.DrawY), 524);
        check("preset_fc", 32'(vga.frame_count), 32'hFFFF);
        fs_pulses = 0;
        for (int i = 0; i < 799; i++) begin
            step();
            if (vga.frame_start === 1'b1) fs_pulses++;
            if (i == 797) begin
                check("prewrap_x", 32'(vga.DrawX), 799);
                check("prewrap_fc", 32'(vga.frame_count), 32'hFFFF);
            end
        end
        check("wrap_fs_pulses", fs_pulses, 1);
        check("wrapfc_fs", 32'(vga.frame_start), 1);
        check("wrapfc_fc", 32'(vga.frame_count), 0);
        check("wrapfc_x", 32'(vga.DrawX), 0);
        check("wrapfc_y", 32'(vga.DrawY), 0);
        step();
        check("wrapfc_fs_next", 32'(vga.frame_start), 0);
        check("wrapfc_fc_next", 32'(vga.frame_count), 0);

        // Reset inside vsync and hsync at (700,491)
        force dut.hc = 10'd690;
        force dut.vc = 10'd491;
        force dut.frame_count = 16'h1234;
        #1;
        release dut.hc;
        release dut.vc;
        release dut.frame_count;
        for (int n = 0; n < 20 && vga.DrawX != 10'd700; n++) step();
        check("mid_x", 32'(vga.DrawX), 700);
        check("mid_y", 32'(vga.DrawY), 491);
        check("mid_hs", 32'(vga.hs), 0);
        check("mid_vs", 32'(vga.vs), 0);
        reset = 1'b1;
        step();
        check("midrst_hs", 32'(vga.hs), 1);
        check("midrst_vs", 32'(vga.vs), 1);
        check("midrst_x", 32'(vga.DrawX), 0);
        check("midrst_y", 32'(vga.DrawY), 0);
        check("midrst_fc", 32'(vga.frame_count), 0);
        check("midrst_blank", 32'(vga.blank), 0);
        check("midrst_fs", 32'(vga.frame_start), 0);
        reset = 1'b0;
        step();
        check("rerun_x", 32'(vga.DrawX), 0);
        check("rerun_blank", 32'(vga.blank), 1);
        check("rerun_fs", 32'(vga.frame_start), 1);
        check("rerun_hs", 32'(vga.hs), 1);
        check("rerun_vs", 32'(vga.vs), 1);
        step();
        check("rerun_x1", 32'(vga.DrawX), 1);
        check("rerun_fs1", 32'(vga.frame_start), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
